spi_flash_reader: RTL and testbench
===================================

# spi_flash_reader

Wishbone-master sequencer that drives the simple_spi controller in the peripheral subsystem to perform SPI NOR flash READ (0x03) transfers without CPU involvement. Accepts a 24-bit flash address and byte count, issues the command/address bytes, clocks out the requested data bytes and delivers them on a valid/ready byte stream. Used as a boot/copy engine sharing the spi_flash Wishbone slave with the CPU path through the interconnect.

## Interface
- `SPR`, 2'b00: SPI clock divider written to SPCR[1:0].
- `POLL_TIMEOUT`, 1023: maximum SPSR polls per byte before abort; counter is 10 bits wide.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_addr`  in  24  flash byte address; captured on start.
- `i_len`  in  16  byte count; captured on start; 0 is legal.
- `o_busy`  out  1  high from the cycle after start acceptance until the done/err cycle.
- `o_done`  out  1  one-cycle pulse on successful completion.
- `o_err`  out  1  one-cycle pulse on abort (wb_err or poll timeout).
- `o_rdata`  out  8  received data byte.
- `o_rvalid`  out  1  o_rdata valid; held until i_rready.
- `i_rready`  in  1  stream consumer ready.
- `o_wb_adr`  out  6  byte address in 64-bit-spaced map: SPCR 0x00, SPSR 0x08, SPDR 0x10, SPER 0x18, SSR 0x20.
- `o_wb_dat`  out  32  write data, bits [31:8] always 0.
- `o_wb_sel`  out  4  always 4'b0001.
- `o_wb_we`  out  1  write enable.
- `o_wb_cyc`, `o_wb_stb`  out  1  classic cycle strobes, always equal.
- `i_wb_rdt`  in  32  read data; only [7:0] used.
- `i_wb_ack`  in  1  acknowledge.
- `i_wb_err`  in  1  error termination.

## Operation
- States: IDLE, CFG, CS_ON, TX, POLL, RX, OUT, CS_OFF, FIN.
- IDLE: on i_start capture addr/len, byte counter = 0, phase = CMD; go to CFG. If i_len == 0 go directly to FIN (no bus activity, o_done pulses).
- CFG: write SPCR = {2'b01, 1'b0, 1'b1, 2'b00, SPR} (spe=1, mstr=1, mode 0).
- CS_ON: write SSR = 0x01 (asserts flash CS).
- TX: write SPDR with next byte: header bytes 0x03, addr[23:16], addr[15:8], addr[7:0], then 0x00 dummies for data phase.
- POLL: read SPSR; if bit0 (rfempty) = 1, repeat POLL and increment timeout counter; else go RX. Counter reset on entry to TX.
- RX: read SPDR. Header phase: discard, after 4th byte switch to DATA phase. Data phase: load o_rdata, go OUT.
- OUT: o_rvalid high until i_rready; on handshake, decrement remaining; if remaining == 0 go CS_OFF, else TX. No further SPDR write while o_rvalid is high.
- CS_OFF: write SSR = 0x00; then FIN.
- FIN: pulse o_done (or o_err on abort path), return IDLE.
- Abort: i_wb_err on any access, or poll count reaching POLL_TIMEOUT, drops the current cycle and goes to CS_OFF with error flag set; CS_OFF's own wb_err goes straight to FIN with error flag. FIN then pulses o_err instead of o_done.
- i_start outside IDLE ignored.

## Timing
- Reset values: o_busy 0, o_done 0, o_err 0, o_rvalid 0, o_rdata 0, o_wb_cyc/stb/we 0, o_wb_adr 0, o_wb_dat 0. Reset mid-transfer returns to IDLE next edge with cyc dropped; CS recovery relies on simple_spi sharing rst_n.
- All outputs registered. Each bus access: cyc/stb/adr/we/dat asserted in state's first cycle, held until ack/err; sampled ack deasserts cyc the next edge; at least one idle cycle (cyc=0) between consecutive accesses.
- i_wb_ack and i_wb_err both high: treated as err.
- o_rvalid rises the cycle after the RX ack; handshake cycle i_rvalid & i_rready clears o_rvalid next edge; o_rdata stable while o_rvalid high.
- o_done/o_err pulse in the same cycle o_busy falls.
- Minimum per data byte (ack latency 1, immediate rfempty=0, i_rready=1): TX 2 + idle 1 + POLL 2 + idle 1 + RX 2 + OUT 1 = 9 cycles.

## Test plan
- Reset: hold rst_n=0 mid-POLL -> next edge all outputs at reset values, state IDLE; new start works normally.
- Read addr 0x123456 len 3, flash model returns 0xA5,0x5A,0xFF -> SPDR writes 0x03,0x12,0x34,0x56,0x00×3; SSR 0x01 then 0x00; stream 0xA5,0x5A,0xFF; single o_done.
- len 0 -> no Wishbone cycle, o_done pulses 2 cycles after start, o_busy high 1 cycle.
- Backpressure: i_rready low 20 cycles on 2nd byte -> o_rvalid/o_rdata stable, no SPDR write during stall, data order preserved.
- Poll timeout: rfempty stuck 1, POLL_TIMEOUT=8 -> 8 SPSR reads, SSR written 0x00, o_err pulse, no o_done.
- wb_err on 2nd header SPDR write -> cycle dropped, SSR 0x00 written, o_err pulse; i_start during busy ignored.

Source files
------------

// File: rtl/spi_flash_reader_if.sv
// Wishbone classic bus bundle between spi_flash_reader (master) and the
// simple_spi register file (slave).
//   o_wb_adr  byte address of the simple_spi register (64-bit spaced)
//   o_wb_dat  write data, only [7:0] carries information
//   o_wb_sel  byte select, lane 0 only
//   o_wb_we   write enable
//   o_wb_cyc  cycle, o_wb_stb strobe (always equal)
//   i_wb_rdt  read data, only [7:0] used
//   i_wb_ack  acknowledge, i_wb_err error termination
interface spi_flash_reader_if;
  logic [5:0]  o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        i_wb_err;

  modport master (
    output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
    input  i_wb_rdt, i_wb_ack, i_wb_err
  );

  modport slave (
    input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
    output i_wb_rdt, i_wb_ack, i_wb_err
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI NOR flash READ (0x03) sequencer. Drives the simple_spi controller over
// Wishbone: configures SPCR, asserts CS via SSR, shifts command/address bytes
// and dummy bytes through SPDR, polls SPSR for received data and streams the
// data bytes out on a valid/ready interface.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_start            start request (IDLE only), i_addr/i_len captured then
//   o_busy             transfer in progress
//   o_done / o_err     one-cycle completion / abort pulse
//   o_rdata, o_rvalid  received data byte stream, i_rready consumer ready
//   wb                 Wishbone master port to simple_spi
module spi_flash_reader #(
  parameter logic [1:0] SPR          = 2'b00,
  parameter int         POLL_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [23:0] i_addr,
  input  logic [15:0] i_len,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_rdata,
  output logic        o_rvalid,
  input  logic        i_rready,
  spi_flash_reader_if.master wb
);

  localparam logic [5:0] ADR_SPCR = 6'h00;
  localparam logic [5:0] ADR_SPSR = 6'h08;
  localparam logic [5:0] ADR_SPDR = 6'h10;
  localparam logic [5:0] ADR_SSR  = 6'h20;
  localparam logic [9:0] POLL_LAST = 10'(POLL_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_CS_ON, S_TX, S_POLL, S_RX, S_OUT, S_CS_OFF, S_FIN
  } state_t;

  state_t      state_reg, state_next;
  state_t      tgt_reg, tgt_next;       // state to enter after the idle gap
  logic        gap_reg, gap_next;       // bus access finished, cyc low this cycle
  logic        cyc_reg, cyc_next;
  logic        we_reg, we_next;
  logic [5:0]  adr_reg, adr_next;
  logic [7:0]  dat_reg, dat_next;
  logic [23:0] addr_reg, addr_next;
  logic [15:0] rem_reg, rem_next;
  logic [1:0]  hdr_cnt_reg, hdr_cnt_next;
  logic        data_ph_reg, data_ph_next;
  logic [9:0]  poll_cnt_reg, poll_cnt_next;
  logic        abort_reg, abort_next;
  logic [7:0]  rdata_reg, rdata_next;
  logic        rvalid_reg, rvalid_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        launch;
  logic [7:0]  tx_byte;
  logic        rdt_unused;

  assign rdt_unused = ^wb.i_wb_rdt[31:8];

  assign wb.o_wb_adr = adr_reg;
  assign wb.o_wb_dat = {24'h0, dat_reg};
  assign wb.o_wb_sel = 4'b0001;
  assign wb.o_wb_we  = we_reg;
  assign wb.o_wb_cyc = cyc_reg;
  assign wb.o_wb_stb = cyc_reg;
  assign o_busy   = busy_reg;
  assign o_done   = done_reg;
  assign o_err    = err_reg;
  assign o_rdata  = rdata_reg;
  assign o_rvalid = rvalid_reg;

  // Header bytes are indexed by how many header responses were drained.
  always_comb begin
    tx_byte = 8'h00;
    if (!data_ph_reg) begin
      case (hdr_cnt_reg)
        2'd0:    tx_byte = 8'h03;
        2'd1:    tx_byte = addr_reg[23:16];
        2'd2:    tx_byte = addr_reg[15:8];
        default: tx_byte = addr_reg[7:0];
      endcase
    end
  end

  always_comb begin
    state_next    = state_reg;
    tgt_next      = tgt_reg;
    gap_next      = gap_reg;
    cyc_next      = cyc_reg;
    we_next       = we_reg;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    addr_next     = addr_reg;
    rem_next      = rem_reg;
    hdr_cnt_next  = hdr_cnt_reg;
    data_ph_next  = data_ph_reg;
    poll_cnt_next = poll_cnt_reg;
    abort_next    = abort_reg;
    rdata_next    = rdata_reg;
    rvalid_next   = rvalid_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    launch        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (i_start) begin
          addr_next    = i_addr;
          rem_next     = i_len;
          hdr_cnt_next = 2'd0;
          data_ph_next = 1'b0;
          abort_next   = 1'b0;
          busy_next    = 1'b1;
          if (i_len == 16'd0) begin
            state_next = S_FIN;
          end else begin
            state_next = S_CFG;
            launch     = 1'b1;
          end
        end
      end
      S_CFG, S_CS_ON, S_TX, S_POLL, S_RX, S_CS_OFF: begin
        if (gap_reg) begin
          gap_next   = 1'b0;
          state_next = tgt_reg;
          launch     = (tgt_reg != S_FIN);
        end else if (cyc_reg && (wb.i_wb_ack || wb.i_wb_err)) begin
          cyc_next = 1'b0;
          gap_next = 1'b1;
          // err wins over a simultaneous ack
          if (wb.i_wb_err) begin
            abort_next = 1'b1;
            tgt_next   = (state_reg == S_CS_OFF) ? S_FIN : S_CS_OFF;
          end else begin
            case (state_reg)
              S_CFG:   tgt_next = S_CS_ON;
              S_CS_ON: tgt_next = S_TX;
              S_TX:    tgt_next = S_POLL;
              S_POLL: begin
                if (!wb.i_wb_rdt[0]) begin
                  tgt_next = S_RX;
                end else if (poll_cnt_reg == POLL_LAST) begin
                  abort_next = 1'b1;
                  tgt_next   = S_CS_OFF;
                end else begin
                  poll_cnt_next = poll_cnt_reg + 10'd1;
                  tgt_next      = S_POLL;
                end
              end
              S_RX: begin
                if (data_ph_reg) begin
                  // OUT itself provides the idle cycle, so no gap here
                  gap_next    = 1'b0;
                  rdata_next  = wb.i_wb_rdt[7:0];
                  rvalid_next = 1'b1;
                  state_next  = S_OUT;
                end else begin
                  hdr_cnt_next = hdr_cnt_reg + 2'd1;
                  if (hdr_cnt_reg == 2'd3) data_ph_next = 1'b1;
                  tgt_next = S_TX;
                end
              end
              default: tgt_next = S_FIN;
            endcase
          end
        end
      end
      S_OUT: begin
        if (i_rready) begin
          rvalid_next = 1'b0;
          rem_next    = rem_reg - 16'd1;
          state_next  = (rem_reg == 16'd1) ? S_CS_OFF : S_TX;
          launch      = 1'b1;
        end
      end
      S_FIN: begin
        done_next  = ~abort_reg;
        err_next   = abort_reg;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Bus signals are registered on the edge that enters the access state.
    if (launch) begin
      cyc_next = 1'b1;
      case (state_next)
        S_CFG:    begin adr_next = ADR_SPCR; we_next = 1'b1; dat_next = {6'b010100, SPR}; end
        S_CS_ON:  begin adr_next = ADR_SSR;  we_next = 1'b1; dat_next = 8'h01; end
        S_TX:     begin adr_next = ADR_SPDR; we_next = 1'b1; dat_next = tx_byte; poll_cnt_next = 10'd0; end
        S_POLL:   begin adr_next = ADR_SPSR; we_next = 1'b0; dat_next = 8'h00; end
        S_RX:     begin adr_next = ADR_SPDR; we_next = 1'b0; dat_next = 8'h00; end
        S_CS_OFF: begin adr_next = ADR_SSR;  we_next = 1'b1; dat_next = 8'h00; end
        default:  cyc_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      tgt_reg      <= S_IDLE;
      gap_reg      <= 1'b0;
      cyc_reg      <= 1'b0;
      we_reg       <= 1'b0;
      adr_reg      <= 6'h00;
      dat_reg      <= 8'h00;
      addr_reg     <= 24'h0;
      rem_reg      <= 16'h0;
      hdr_cnt_reg  <= 2'd0;
      data_ph_reg  <= 1'b0;
      poll_cnt_reg <= 10'd0;
      abort_reg    <= 1'b0;
      rdata_reg    <= 8'h00;
      rvalid_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tgt_reg      <= tgt_next;
      gap_reg      <= gap_next;
      cyc_reg      <= cyc_next;
      we_reg       <= we_next;
      adr_reg      <= adr_next;
      dat_reg      <= dat_next;
      addr_reg     <= addr_next;
      rem_reg      <= rem_next;
      hdr_cnt_reg  <= hdr_cnt_next;
      data_ph_reg  <= data_ph_next;
      poll_cnt_reg <= poll_cnt_next;
      abort_reg    <= abort_next;
      rdata_reg    <= rdata_next;
      rvalid_reg   <= rvalid_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
module tb_spi_flash_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [23:0] i_addr = 24'h0;
  logic [15:0] i_len = 16'h0;
  logic        o_busy, o_done, o_err, o_rvalid;
  logic [7:0]  o_rdata;
  logic        i_rready = 1'b1;

  spi_flash_reader_if wb();

  spi_flash_reader #(.SPR(2'b00), .POLL_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_addr(i_addr), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .wb(wb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // flash contents (low address byte indexes the array)
  logic [7:0] flash [256];
  logic [7:0] exp_q[$];     // scoreboard of expected stream bytes
  logic [7:0] spdr_log[$];
  logic [7:0] ssr_log[$];
  logic [7:0] rxfifo[$];
  int viol = 0, done_cnt = 0, err_cnt = 0, spsr_reads = 0, acc_cnt = 0, rx_idx = 0;
  int err_on_spdr = 0, spdr_wr_n = 0, stall_on_byte = -1, stall_left = 0;
  bit stuck_empty = 0, rand_ready = 0;

  // simple_spi + flash behavioural slave
  initial begin
    bit in_acc;
    int wait_cnt, nbytes, pend;
    logic [23:0] fa;
    logic [7:0] resp;
    in_acc = 0; wait_cnt = 0; nbytes = 0; pend = 0; fa = 0;
    wb.i_wb_ack = 0; wb.i_wb_err = 0; wb.i_wb_rdt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        wb.i_wb_ack = 0; wb.i_wb_err = 0; in_acc = 0; pend = 0; rxfifo.delete();
      end else if (wb.i_wb_ack || wb.i_wb_err) begin
        wb.i_wb_ack = 0; wb.i_wb_err = 0; in_acc = 0;
        if (wb.o_wb_cyc) viol++;
      end else if (wb.o_wb_cyc) begin
        if (!in_acc) begin
          in_acc = 1;
          wait_cnt = $urandom_range(0, 2);
          if (wb.o_wb_stb !== 1'b1 || wb.o_wb_sel !== 4'b0001 || wb.o_wb_dat[31:8] !== 24'h0) viol++;
        end
        if (wait_cnt > 0) wait_cnt--;
        else begin
          acc_cnt++;
          wb.i_wb_rdt = 32'h0;
          if (wb.o_wb_we && wb.o_wb_adr == 6'h10) spdr_wr_n++;
          if (err_on_spdr > 0 && wb.o_wb_we && wb.o_wb_adr == 6'h10 && spdr_wr_n == err_on_spdr) begin
            wb.i_wb_err = 1;
          end else begin
            wb.i_wb_ack = 1;
            if (wb.o_wb_we) begin
              case (wb.o_wb_adr)
                6'h00: if (wb.o_wb_dat[7:0] != 8'h50) viol++;
                6'h20: begin ssr_log.push_back(wb.o_wb_dat[7:0]); if (wb.o_wb_dat[0]) nbytes = 0; end
                6'h10: begin
                  spdr_log.push_back(wb.o_wb_dat[7:0]);
                  if (o_rvalid) viol++;
                  if (nbytes == 1) fa[23:16] = wb.o_wb_dat[7:0];
                  if (nbytes == 2) fa[15:8] = wb.o_wb_dat[7:0];
                  if (nbytes == 3) fa[7:0] = wb.o_wb_dat[7:0];
                  resp = (nbytes >= 4) ? flash[8'(fa[7:0] + 8'(nbytes - 4))] : 8'hFF;
                  rxfifo.push_back(resp);
                  nbytes++;
                  pend = $urandom_range(0, 3);
                end
                default: viol++;
              endcase
            end else begin
              case (wb.o_wb_adr)
                6'h08: begin
                  spsr_reads++;
                  if (stuck_empty) wb.i_wb_rdt[0] = 1'b1;
                  else if (pend > 0) begin pend--; wb.i_wb_rdt[0] = 1'b1; end
                  else wb.i_wb_rdt[0] = (rxfifo.size() == 0);
                end
                6'h10: if (rxfifo.size() > 0) wb.i_wb_rdt[7:0] = rxfifo.pop_front();
                default: viol++;
              endcase
            end
          end
        end
      end
    end
  end

  // consumer ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin i_rready = 0; stall_left--; end
      else if (stall_on_byte >= 0 && o_rvalid && rx_idx == stall_on_byte) begin
        stall_on_byte = -1; stall_left = 19; i_rready = 0;
      end else i_rready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // monitor: pops scoreboard on each stream handshake
  initial begin
    logic pv, phs;
    logic [7:0] pd;
    pv = 0; phs = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_rvalid && pv && !phs && o_rdata !== pd) viol++;
        if ((o_done || o_err) && o_busy) viol++;
        if (o_done) done_cnt++;
        if (o_err) err_cnt++;
        if (o_rvalid && i_rready) begin
          if (exp_q.size() == 0) check("stream_extra_byte", {56'h0, o_rdata}, 64'h100);
          else check("stream_byte", {56'h0, o_rdata}, {56'h0, exp_q.pop_front()});
          rx_idx++;
        end
      end
      pv = o_rvalid; pd = o_rdata; phs = o_rvalid & i_rready;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic pulse_start(input logic [23:0] a, input logic [15:0] l);
    @(posedge clk); #1;
    i_addr = a; i_len = l; i_start = 1;
    @(posedge clk); #1;
    i_start = 0;
  endtask

  function automatic logic [63:0] out_vec();
    return {o_busy, o_done, o_err, o_rvalid, o_rdata, wb.o_wb_cyc, wb.o_wb_stb,
            wb.o_wb_we, wb.o_wb_adr, wb.o_wb_dat};
  endfunction

  // mode 0 normal, 1 poll timeout, 2 wb_err on 2nd SPDR write + start while busy
  task automatic run_txn(input int id, input logic [23:0] a, input int l, input int mode);
    logic [7:0] exp_w[$];
    bit seen;
    int bad, acc_snap;
    spdr_log.delete(); ssr_log.delete(); exp_q.delete();
    viol = 0; done_cnt = 0; err_cnt = 0; spsr_reads = 0; rx_idx = 0; spdr_wr_n = 0;
    stuck_empty = (mode == 1);
    err_on_spdr = (mode == 2) ? 2 : 0;
    exp_w.push_back(8'h03);
    if (mode == 0) begin
      exp_w.push_back(a[23:16]); exp_w.push_back(a[15:8]); exp_w.push_back(a[7:0]);
      for (int i = 0; i < l; i++) begin
        exp_w.push_back(8'h00);
        exp_q.push_back(flash[8'(a[7:0] + 8'(i))]);
      end
    end
    pulse_start(a, 16'(l));
    if (mode == 2) begin
      repeat (3) @(posedge clk);
      #1; i_addr = ~a; i_len = 16'd5; i_start = 1;
      @(posedge clk); #1; i_start = 0;
    end
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk); #1;
      if (o_done || o_err) seen = 1;
    end
    check("end_pulse_seen", {63'h0, seen}, 64'h1);
    acc_snap = acc_cnt;
    repeat ((mode == 2) ? 15 : 4) @(posedge clk);
    #1;
    check("done_count", done_cnt, (mode == 0) ? 1 : 0);
    check("err_count", err_cnt, (mode == 0) ? 0 : 1);
    check("stream_left", exp_q.size(), 0);
    check("spdr_write_count", spdr_log.size(), exp_w.size());
    bad = -1;
    for (int i = 0; i < spdr_log.size() && i < exp_w.size(); i++)
      if (bad < 0 && spdr_log[i] !== exp_w[i]) bad = i;
    check("spdr_first_bad_index", bad, -1);
    check("ssr_write_count", ssr_log.size(), 2);
    if (ssr_log.size() == 2) check("ssr_values", {ssr_log[0], ssr_log[1]}, 16'h0100);
    check("protocol_violations", viol, 0);
    if (mode == 1) check("spsr_reads", spsr_reads, 8);
    if (mode == 2) begin
      check("no_access_after_end", acc_cnt, acc_snap);
      check("idle_after_end", {o_busy, wb.o_wb_cyc}, 2'b00);
    end
    $display("txn %0d addr=%06h len=%0d mode=%0d done=%0d err=%0d spdr_writes=%0d", id, a, l, mode,
             done_cnt, err_cnt, spdr_log.size());
  endtask

  initial begin
    bit seen;
    int acc_snap;
    for (int i = 0; i < 256; i++) flash[i] = 8'($urandom);
    flash[8'h56] = 8'hA5; flash[8'h57] = 8'h5A; flash[8'h58] = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 64'h0);
    rst_n = 1;

    run_txn(1, 24'h123456, 3, 0);

    // zero length: no bus activity, busy one cycle, done two cycles after start
    acc_snap = acc_cnt; done_cnt = 0;
    @(posedge clk); #1;
    i_addr = 24'h000010; i_len = 16'd0; i_start = 1;
    @(posedge clk); #1; i_start = 0;
    check("len0_busy_cycle1", {o_busy, o_done}, 2'b10);
    @(posedge clk); #1;
    check("len0_done_cycle2", {o_busy, o_done}, 2'b01);
    repeat (3) @(posedge clk);
    #1;
    check("len0_no_bus", acc_cnt, acc_snap);
    check("len0_single_done", done_cnt, 1);
    $display("txn 2 addr=000010 len=0 done=%0d accesses=%0d", done_cnt, acc_cnt - acc_snap);

    stall_on_byte = 1;
    run_txn(3, 24'h0200F0, 4, 0);
    stall_on_byte = -1;
    run_txn(4, 24'h001100, 2, 1);
    run_txn(5, 24'h00AA00, 2, 2);

    // reset mid-POLL
    pulse_start(24'h0ABCDE, 16'd2);
    seen = 0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(posedge clk); #1;
      if (wb.o_wb_cyc && wb.o_wb_adr == 6'h08 && !wb.o_wb_we) seen = 1;
    end
    check("reached_poll", {63'h0, seen}, 64'h1);
    rst_n = 0;
    @(posedge clk); #1;
    check("reset_mid_poll_outputs", out_vec(), 64'h0);
    @(posedge clk); #1;
    rst_n = 1;
    $display("txn 6 addr=0abcde len=2 reset mid-poll");
    run_txn(7, 24'h0ABCDE, 2, 0);

    rand_ready = 1;
    for (int t = 0; t < 12; t++)
      run_txn(8 + t, 24'($urandom), $urandom_range(1, 6), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
